// File: rtl/chan_pkg.sv
// Shared definitions for the per-channel block buffer: word width, FSM state encodings, gap length.
package chan_pkg;

    localparam int WORD_W     = 16;
    localparam int GAP_CYCLES = 2;

    typedef enum logic [0:0] {
        WFILL = 1'b0,
        WDROP = 1'b1
    } wstate_e;

    typedef enum logic [1:0] {
        RIDLE = 2'd0,
        RSEND = 2'd1,
        RGAP  = 2'd2
    } rstate_e;

endpackage

// File: rtl/chan_blkbuf_if.sv
// Channel-side write port and arbiter-side req/ack port of the block buffer, plus FSM debug state.
// `lost` exists only when CHAN_BLKBUF_LOSTCNT_EN is defined.
interface chan_blkbuf_if #(
    parameter int ADDR_W = 9
);
    // Handshake: req=1 means data holds a committed word; ack in cycle t+1 consumes the word
    // shown in cycle t, and data in the ack cycle already shows the following word.
    logic [chan_pkg::WORD_W-1:0] wr_data;
    logic                        wr_en;
    logic                        wr_end;
    logic [chan_pkg::WORD_W-1:0] data;
    logic                        req;
    logic                        ack;
    logic [ADDR_W:0]             blocks;
    logic                        ovf;
`ifdef CHAN_BLKBUF_LOSTCNT_EN
    logic [15:0]                 lost;
`endif
    logic [0:0]                  dbg_wstate;
    logic [1:0]                  dbg_rstate;

    modport master (
        output wr_data, wr_en, wr_end, ack,
        input  data, req, blocks, ovf,
`ifdef CHAN_BLKBUF_LOSTCNT_EN
        input  lost,
`endif
        input  dbg_wstate, dbg_rstate
    );

    modport slave (
        input  wr_data, wr_en, wr_end, ack,
        output data, req, blocks, ovf,
`ifdef CHAN_BLKBUF_LOSTCNT_EN
        output lost,
`endif
        output dbg_wstate, dbg_rstate
    );

endinterface

// File: rtl/blkbuf_ram.sv
// Simple dual-port block storage: one write port, asynchronous reads at raddr and raddr+1.
// sel_i picks the look-ahead word; rend_o is always the end bit of the word at raddr.
module blkbuf_ram #(
    parameter int ADDR_W = 9,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W:0]   wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    input  logic              sel_i,
    output logic [WORD_W-1:0] rword_o,
    output logic              rend_o
);

    logic [WORD_W:0]   mem_q [2**ADDR_W];
    logic [ADDR_W-1:0] raddr_nxt;

    assign raddr_nxt = raddr_i + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rword_o = sel_i ? mem_q[raddr_nxt][WORD_W-1:0] : mem_q[raddr_i][WORD_W-1:0];
    assign rend_o  = mem_q[raddr_i][WORD_W];

endmodule

// File: rtl/chan_blkbuf.sv
// Per-channel block buffer: commits only complete blocks and streams them to the link arbiter.
// CHAN_BLKBUF_LOSTCNT_EN adds the saturating discarded-block counter on `lost`.
module chan_blkbuf
    import chan_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input logic          clk,
    input logic          rst_n,
    chan_blkbuf_if.slave bus
);

    localparam int              PW     = ADDR_W + 1;
    localparam logic [PW-1:0]   DEPTH  = PW'(1) << ADDR_W;
    localparam logic [0:0]      W_FILL = WFILL;
    localparam logic [0:0]      W_DROP = WDROP;
    localparam logic [1:0]      R_IDLE = RIDLE;
    localparam logic [1:0]      R_SEND = RSEND;
    localparam logic [1:0]      R_GAP  = RGAP;
    localparam logic [1:0]      GAP_LD = 2'(GAP_CYCLES - 1);

    logic [0:0]        wstate_q, wstate_d;
    logic [1:0]        rstate_q, rstate_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     cptr_q, cptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [PW-1:0]     blocks_q, blocks_d;
    logic [1:0]        gap_q, gap_d;
    logic              ovf_q;

    logic [PW-1:0]     used;
    logic              full;
    logic              mem_we;
    logic              blk_inc, blk_dec;
    logic              ovf_evt;
    logic              pop, pop_end;
    logic              req;
    logic [WORD_W-1:0] rd_word;
    logic              rd_end;

    assign used = wptr_q - rptr_q;
    assign full = (used == DEPTH);

    blkbuf_ram #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wptr_q[ADDR_W-1:0]),
        .wdata_i ({bus.wr_end, bus.wr_data}),
        .raddr_i (rptr_q[ADDR_W-1:0]),
        .sel_i   (pop),
        .rword_o (rd_word),
        .rend_o  (rd_end)
    );

    // Write side: a full buffer rewinds wptr to the last commit, discarding the open block.
    always_comb begin
        wstate_d = wstate_q;
        wptr_d   = wptr_q;
        cptr_d   = cptr_q;
        mem_we   = 1'b0;
        blk_inc  = 1'b0;
        ovf_evt  = 1'b0;
        case (wstate_q)
            W_FILL: begin
                if (bus.wr_en) begin
                    if (!full) begin
                        mem_we = 1'b1;
                        wptr_d = wptr_q + PW'(1);
                        if (bus.wr_end) begin
                            cptr_d  = wptr_q + PW'(1);
                            blk_inc = 1'b1;
                        end
                    end else begin
                        wptr_d  = cptr_q;
                        ovf_evt = 1'b1;
                        if (!bus.wr_end) begin
                            wstate_d = W_DROP;
                        end
                    end
                end
            end
            default: begin
                if (bus.wr_en && bus.wr_end) begin
                    wstate_d = W_FILL;
                end
            end
        endcase
    end

    // Only RSEND accepts ack; RSEND is entered only after a cycle with req high.
    assign pop     = (rstate_q == R_SEND) && bus.ack;
    assign pop_end = pop && rd_end;

    always_comb begin
        rstate_d = rstate_q;
        rptr_d   = rptr_q;
        gap_d    = gap_q;
        blk_dec  = 1'b0;
        req      = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                req = (blocks_q != '0);
                if (blocks_q != '0) begin
                    rstate_d = R_SEND;
                end
            end
            R_SEND: begin
                req = !pop_end;
                if (pop) begin
                    rptr_d = rptr_q + PW'(1);
                end
                if (pop_end) begin
                    blk_dec  = 1'b1;
                    gap_d    = GAP_LD;
                    rstate_d = R_GAP;
                end
            end
            R_GAP: begin
                if (gap_q == 2'd0) begin
                    rstate_d = R_IDLE;
                end else begin
                    gap_d = gap_q - 2'd1;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        blocks_d = blocks_q;
        case ({blk_inc, blk_dec})
            2'b10:   blocks_d = blocks_q + PW'(1);
            2'b01:   blocks_d = blocks_q - PW'(1);
            default: blocks_d = blocks_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wstate_q <= W_FILL;
            rstate_q <= R_IDLE;
            wptr_q   <= '0;
            cptr_q   <= '0;
            rptr_q   <= '0;
            blocks_q <= '0;
            gap_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            wptr_q   <= wptr_d;
            cptr_q   <= cptr_d;
            rptr_q   <= rptr_d;
            blocks_q <= blocks_d;
            gap_q    <= gap_d;
            ovf_q    <= ovf_evt;
        end
    end

`ifdef CHAN_BLKBUF_LOSTCNT_EN
    logic [15:0] lost_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lost_q <= '0;
        end else if (ovf_evt && (lost_q != 16'hFFFF)) begin
            lost_q <= lost_q + 16'd1;
        end
    end

    assign bus.lost = lost_q;
`endif

    // Storage is unreset, so data is forced to 0 while nothing is committed.
    assign bus.data       = (blocks_q != '0) ? rd_word : '0;
    assign bus.req        = req;
    assign bus.blocks     = blocks_q;
    assign bus.ovf        = ovf_q;
    assign bus.dbg_wstate = wstate_q;
    assign bus.dbg_rstate = rstate_q;

endmodule

// File: tb/tb_chan_blkbuf.sv
// Self-checking bench for chan_blkbuf: cycle table for streaming/stall cases, then
// hand-written overflow, simultaneous commit/drain and mid-block reset sequences.
module tb_chan_blkbuf;

  logic clk;
  logic rst_n;

  chan_blkbuf_if #(.ADDR_W(9)) bus ();

  chan_blkbuf #(.ADDR_W(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic        wend;
    logic [15:0] wd;
    logic        ack;
    logic        ereq;
    logic [9:0]  eblk;
    logic        cd;
    logic [15:0] edata;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] exp_q[$];
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  logic        arb_en    = 1'b0;
  logic        arb_take  = 1'b0;
  logic        saw_ovf   = 1'b0;
  logic        seen_high = 1'b0;
  int          low_run   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic add(input logic we, input logic wend, input logic [15:0] wd, input logic ack,
                     input logic ereq, input logic [9:0] eblk, input logic cd,
                     input logic [15:0] edata);
    vec_t v;
    v.we = we; v.wend = wend; v.wd = wd; v.ack = ack;
    v.ereq = ereq; v.eblk = eblk; v.cd = cd; v.edata = edata;
    vecs.push_back(v);
  endtask

  // driver: one cycle with the arbiter model generating ack and the scoreboard checking words
  task automatic step(input logic we, input logic wend, input logic [15:0] wd);
    bus.wr_en   = we;
    bus.wr_end  = wend;
    bus.wr_data = wd;
    bus.ack     = arb_take;
    #1;
    saw_ovf = bus.ovf;
    if (bus.req) begin
      if (seen_high && low_run > 0) begin
        total_cnt++;
        if (low_run >= 3) pass_cnt++;
        else $display("FAIL req_gap: req low for %0d cycles, required >= 3", low_run);
      end
      seen_high = 1'b1;
      low_run   = 0;
      if (arb_en) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL extra_word: got 0x%0h, required no word", bus.data);
        end else begin
          check("word", {16'h0, bus.data}, {16'h0, exp_q.pop_front()});
        end
      end
    end else begin
      low_run++;
    end
    arb_take = arb_en && bus.req;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1'b0, 1'b0, 16'h0);
      n++;
    end
    check("drain_words_left", exp_q.size(), 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0);
    check("drain_blocks", {22'h0, bus.blocks}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int ovf_cnt;
    int ovf_word;

    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_end  = 1'b0;
    bus.wr_data = 16'h0;
    bus.ack     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_req", {31'h0, bus.req}, 0);
    check("rst_blocks", {22'h0, bus.blocks}, 0);
    check("rst_ovf", {31'h0, bus.ovf}, 0);
    check("rst_data", {16'h0, bus.data}, 0);
    check("rst_wstate", {31'h0, bus.dbg_wstate}, 0);
    check("rst_rstate", {30'h0, bus.dbg_rstate}, 0);
`ifdef CHAN_BLKBUF_LOSTCNT_EN
    check("rst_lost", {16'h0, bus.lost}, 0);
`endif
    @(posedge clk);
    #1;

    // 3-word block, continuous acks
    add(1,0,16'h1111,0, 0,0,1,16'h0);
    add(1,0,16'h2222,0, 0,0,1,16'h0);
    add(1,1,16'h3333,0, 0,0,1,16'h0);
    add(0,0,16'h0,0,    1,1,1,16'h1111);
    add(0,0,16'h0,1,    1,1,1,16'h2222);
    add(0,0,16'h0,1,    1,1,1,16'h3333);
    add(0,0,16'h0,1,    0,1,0,16'h0);
    add(0,0,16'h0,0,    0,0,0,16'h0);
    add(0,0,16'h0,0,    0,0,0,16'h0);
    add(0,0,16'h0,0,    0,0,1,16'h0);
    // two 2-word blocks committed back-to-back
    add(1,0,16'hA001,0, 0,0,1,16'h0);
    add(1,1,16'hA002,0, 0,0,1,16'h0);
    add(1,0,16'hB001,0, 1,1,1,16'hA001);
    add(1,1,16'hB002,0, 1,1,1,16'hA001);
    add(0,0,16'h0,0,    1,2,1,16'hA001);
    add(0,0,16'h0,1,    1,2,1,16'hA002);
    add(0,0,16'h0,1,    0,2,0,16'h0);
    add(0,0,16'h0,0,    0,1,0,16'h0);
    add(0,0,16'h0,0,    0,1,0,16'h0);
    add(0,0,16'h0,0,    1,1,1,16'hB001);
    add(0,0,16'h0,1,    1,1,1,16'hB002);
    add(0,0,16'h0,1,    0,1,0,16'h0);
    add(0,0,16'h0,0,    0,0,0,16'h0);
    add(0,0,16'h0,0,    0,0,0,16'h0);
    add(0,0,16'h0,0,    0,0,1,16'h0);
    // 4-word block with a 5-cycle ack stall after the first word
    add(1,0,16'hC001,0, 0,0,1,16'h0);
    add(1,0,16'hC002,0, 0,0,1,16'h0);
    add(1,0,16'hC003,0, 0,0,1,16'h0);
    add(1,1,16'hC004,0, 0,0,1,16'h0);
    add(0,0,16'h0,0,    1,1,1,16'hC001);
    add(0,0,16'h0,1,    1,1,1,16'hC002);
    for (int i = 0; i < 5; i++) add(0,0,16'h0,0, 1,1,1,16'hC002);
    add(0,0,16'h0,1,    1,1,1,16'hC003);
    add(0,0,16'h0,1,    1,1,1,16'hC004);
    add(0,0,16'h0,1,    0,1,0,16'h0);
    add(0,0,16'h0,0,    0,0,0,16'h0);
    add(0,0,16'h0,0,    0,0,0,16'h0);
    add(0,0,16'h0,0,    0,0,1,16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.wr_en   = vecs[i].we;
      bus.wr_end  = vecs[i].wend;
      bus.wr_data = vecs[i].wd;
      bus.ack     = vecs[i].ack;
      #1;
      check($sformatf("row%0d_req", i), {31'h0, bus.req}, {31'h0, vecs[i].ereq});
      check($sformatf("row%0d_blocks", i), {22'h0, bus.blocks}, {22'h0, vecs[i].eblk});
      check($sformatf("row%0d_ovf", i), {31'h0, bus.ovf}, 0);
      if (vecs[i].cd) check($sformatf("row%0d_data", i), {16'h0, bus.data}, {16'h0, vecs[i].edata});
      @(posedge clk);
      #1;
    end

    // 600-word block overflows at word 513, then a 4-word block must pass intact
    arb_en    = 1'b1;
    arb_take  = 1'b0;
    seen_high = 1'b0;
    ovf_cnt   = 0;
    ovf_word  = 0;
    for (int k = 1; k <= 600; k++) begin
      step(1'b1, (k == 600), 16'(k));
      if (saw_ovf) begin
        ovf_cnt++;
        ovf_word = k - 1;
      end
    end
    step(1'b0, 1'b0, 16'h0);
    if (saw_ovf) ovf_cnt++;
    check("ovf_pulses", ovf_cnt, 1);
    check("ovf_word", ovf_word, 513);
    check("ovf_blocks", {22'h0, bus.blocks}, 0);
    check("ovf_req", {31'h0, bus.req}, 0);
`ifdef CHAN_BLKBUF_LOSTCNT_EN
    check("ovf_lost", {16'h0, bus.lost}, 1);
`endif
    for (int k = 0; k < 4; k++) exp_q.push_back(16'hD001 + 16'(k));
    for (int k = 0; k < 4; k++) step(1'b1, (k == 3), 16'hD001 + 16'(k));
    drain(50);

    // commit of a 1-word block in the same cycle as the end-word ack
    seen_high = 1'b0;
    exp_q.push_back(16'hE001);
    exp_q.push_back(16'hE002);
    exp_q.push_back(16'hE003);
    exp_q.push_back(16'hF001);
    step(1'b1, 1'b0, 16'hE001);
    step(1'b1, 1'b0, 16'hE002);
    step(1'b1, 1'b1, 16'hE003);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    check("simul_blocks_before", {22'h0, bus.blocks}, 1);
    step(1'b1, 1'b1, 16'hF001);
    check("simul_blocks_after", {22'h0, bus.blocks}, 1);
    check("simul_req_gap", {31'h0, bus.req}, 0);
    drain(50);

    // reset during RSEND discards everything; the next block starts from its first word
    arb_en   = 1'b0;
    arb_take = 1'b0;
    step(1'b1, 1'b0, 16'h9001);
    step(1'b1, 1'b0, 16'h9002);
    step(1'b1, 1'b1, 16'h9003);
    step(1'b0, 1'b0, 16'h0);
    bus.ack = 1'b1;
    rst_n   = 1'b0;
    #1;
    check("pre_rst_req", {31'h0, bus.req}, 1);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    bus.ack = 1'b0;
    #1;
    check("post_rst_req", {31'h0, bus.req}, 0);
    check("post_rst_blocks", {22'h0, bus.blocks}, 0);
    check("post_rst_data", {16'h0, bus.data}, 0);
    @(posedge clk);
    #1;
    arb_en    = 1'b1;
    seen_high = 1'b0;
    exp_q.push_back(16'h7001);
    exp_q.push_back(16'h7002);
    step(1'b1, 1'b0, 16'h7001);
    step(1'b1, 1'b1, 16'h7002);
    drain(50);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
